// File: rtl/iob_master.sv
// I/O bus master: runs 68000-style asynchronous bus cycles (AS/LDS/UDS/VMA/E)
// for the I/O bridge slave and reports DTACK/BERR completion status back to it.
`timescale 1ns/1ps
module iob_master #(
  parameter int unsigned TO_MAX = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic IOREQ,
  input  logic IORW,
  input  logic IOL,
  input  logic IOU,
  input  logic nDTACK,
  input  logic nBERR,
  input  logic nVPA,
  output logic IOACT,
  output logic nIODTACK,
  output logic nIOBERR,
  output logic nAS,
  output logic nLDS,
  output logic nUDS,
  output logic IORW_o,
  output logic nVMA,
  output logic E,
  output logic nDoutOE,
  output logic nDinLE
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_VW, ST_S5, ST_S6, ST_S7
  } state_t;

  localparam int unsigned     WD_W      = $clog2(TO_MAX + 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TO_MAX - 1);
  localparam logic [4:0]      ECNT_LAST = 5'd19;
  localparam logic [4:0]      ECNT_E_HI = 5'd12;
  localparam logic [4:0]      ECNT_VMA  = 5'd8;

  state_t          state_q, state_d;
  logic [4:0]      ecnt_q, ecnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            rw_q, rw_d, l_q, l_d, u_q, u_d, berr_q, berr_d;
  logic [2:0]      sync1_q, sync2_q;

  logic ioact_q, ioact_d, niodtack_q, niodtack_d, nioberr_q, nioberr_d;
  logic nas_q, nas_d, nlds_q, nlds_d, nuds_q, nuds_d, iorw_q, iorw_d;
  logic nvma_q, nvma_d, e_q, e_d, ndoutoe_q, ndoutoe_d, ndinle_q, ndinle_d;

  logic dts, bes, vps, timeout, bus_win, strb_win;

  // Two-flop synchronizers, ordered {nVPA, nBERR, nDTACK}; idle value is deasserted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {nVPA, nBERR, nDTACK};
      sync2_q <= sync1_q;
    end
  end

  assign dts     = ~sync2_q[0];
  assign timeout = (wd_q == WD_LAST);
  assign bes     = ~sync2_q[1] | timeout;
  assign vps     = ~sync2_q[2];

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    l_d     = l_q;
    u_d     = u_q;
    berr_d  = berr_q;
    wd_d    = wd_q;
    ecnt_d  = (ecnt_q == ECNT_LAST) ? '0 : ecnt_q + 5'd1;

    case (state_q)
      ST_IDLE: begin
        if (IOREQ) begin
          state_d = ST_S0;
          rw_d    = IORW;
          l_d     = IOL;
          u_d     = IOU;
        end
      end
      ST_S0: begin
        wd_d    = '0;
        berr_d  = 1'b0;
        state_d = ST_S1;
      end
      ST_S1: state_d = ST_S2;
      ST_S2: state_d = ST_S3;
      ST_S3: state_d = ST_S4;
      ST_S4: begin
        if (!timeout) wd_d = wd_q + 1'b1;
        if (bes) begin
          berr_d  = 1'b1;
          state_d = ST_S5;
        end else if (dts) begin
          state_d = ST_S5;
        end else if (vps) begin
          state_d = ST_VW;
        end
      end
      ST_VW: begin
        if (!timeout) wd_d = wd_q + 1'b1;
        if (bes) begin
          berr_d  = 1'b1;
          state_d = ST_S5;
        end else if (!nvma_q && ecnt_q == ECNT_LAST) begin
          state_d = ST_S5;
        end
      end
      ST_S5: state_d = ST_S6;
      ST_S6: state_d = ST_S7;
      ST_S7: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pin changes on the state edge.
  always_comb begin
    ioact_d    = (state_d != ST_IDLE);
    niodtack_d = niodtack_q;
    nioberr_d  = nioberr_q;
    if (state_q == ST_IDLE && state_d == ST_S0) begin
      niodtack_d = 1'b1;
      nioberr_d  = 1'b1;
    end else if (state_q == ST_S6 && state_d == ST_S7) begin
      if (berr_q) nioberr_d  = 1'b0;
      else        niodtack_d = 1'b0;
    end

    bus_win  = state_d inside {ST_S2, ST_S3, ST_S4, ST_VW, ST_S5, ST_S6};
    strb_win = rw_d ? bus_win : (state_d inside {ST_S4, ST_VW, ST_S5, ST_S6});

    nas_d     = ~bus_win;
    nlds_d    = ~(strb_win & l_d);
    nuds_d    = ~(strb_win & u_d);
    iorw_d    = (state_d == ST_IDLE) ? 1'b1 : rw_d;
    ndoutoe_d = ~(bus_win & ~rw_d);
    ndinle_d  = state_d inside {ST_S6, ST_S7};
    e_d       = (ecnt_d >= ECNT_E_HI);

    nvma_d = nvma_q;
    if (state_d inside {ST_IDLE, ST_S7}) nvma_d = 1'b1;
    else if (state_d == ST_VW && ecnt_d == ECNT_VMA) nvma_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ecnt_q     <= '0;
      wd_q       <= '0;
      rw_q       <= 1'b1;
      l_q        <= 1'b0;
      u_q        <= 1'b0;
      berr_q     <= 1'b0;
      ioact_q    <= 1'b0;
      niodtack_q <= 1'b1;
      nioberr_q  <= 1'b1;
      nas_q      <= 1'b1;
      nlds_q     <= 1'b1;
      nuds_q     <= 1'b1;
      iorw_q     <= 1'b1;
      nvma_q     <= 1'b1;
      e_q        <= 1'b0;
      ndoutoe_q  <= 1'b1;
      ndinle_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ecnt_q     <= ecnt_d;
      wd_q       <= wd_d;
      rw_q       <= rw_d;
      l_q        <= l_d;
      u_q        <= u_d;
      berr_q     <= berr_d;
      ioact_q    <= ioact_d;
      niodtack_q <= niodtack_d;
      nioberr_q  <= nioberr_d;
      nas_q      <= nas_d;
      nlds_q     <= nlds_d;
      nuds_q     <= nuds_d;
      iorw_q     <= iorw_d;
      nvma_q     <= nvma_d;
      e_q        <= e_d;
      ndoutoe_q  <= ndoutoe_d;
      ndinle_q   <= ndinle_d;
    end
  end

  assign IOACT    = ioact_q;
  assign nIODTACK = niodtack_q;
  assign nIOBERR  = nioberr_q;
  assign nAS      = nas_q;
  assign nLDS     = nlds_q;
  assign nUDS     = nuds_q;
  assign IORW_o   = iorw_q;
  assign nVMA     = nvma_q;
  assign E        = e_q;
  assign nDoutOE  = ndoutoe_q;
  assign nDinLE   = ndinle_q;

endmodule

// File: tb/tb_iob_master.sv
// Directed bench for iob_master: cycle-indexed transfer profiles against hand-derived values.
`timescale 1ns/1ps
module tb_iob_master;

  localparam int PRE   = -1;
  localparam int NEVER = 9999;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ioreq = 1'b0, iorw = 1'b1, iol = 1'b0, iou = 1'b0;
  logic ndtack = 1'b1, nberr = 1'b1, nvpa = 1'b1;
  logic ioact, niodtack, nioberr, nas, nlds, nuds, iorw_o, nvma, e, ndoutoe, ndinle;

  int n_checks = 0;
  int n_fail   = 0;
  int mdl_ecnt;

  int r_act, r_as_first, r_as_cnt, r_lds_first, r_lds_cnt, r_uds_cnt;
  int r_oe_first, r_oe_cnt, r_rwlo_cnt, r_dtk_first, r_be_first;
  int r_vma_first, r_vma_cnt, r_ebad, r_done;

  iob_master #(.TO_MAX(255)) dut (
    .CLK(clk), .RST(rst), .IOREQ(ioreq), .IORW(iorw), .IOL(iol), .IOU(iou),
    .nDTACK(ndtack), .nBERR(nberr), .nVPA(nvpa),
    .IOACT(ioact), .nIODTACK(niodtack), .nIOBERR(nioberr),
    .nAS(nas), .nLDS(nlds), .nUDS(nuds), .IORW_o(iorw_o), .nVMA(nvma),
    .E(e), .nDoutOE(ndoutoe), .nDinLE(ndinle)
  );

  always #5 clk = ~clk;

  // Reference E counter: free-running 0..19 from reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) mdl_ecnt <= 0;
    else     mdl_ecnt <= (mdl_ecnt == 19) ? 0 : mdl_ecnt + 1;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int out_vec();
    return int'({ioact, niodtack, nioberr, nas, nlds, nuds, iorw_o, nvma, e, ndoutoe, ndinle});
  endfunction

  // Sample index j = edges since the accepting edge k; terminations are driven after sample j.
  task automatic run_xfer(input logic rw, input logic lb, input logic ub,
                          input int dt_at, input int be_at, input int vp_at,
                          input int ecnt_start);
    bit seen, done;
    int guard;
    @(negedge clk);
    if (ecnt_start >= 0) begin
      guard = 0;
      while (mdl_ecnt != ecnt_start && guard < 40) begin
        @(negedge clk);
        guard++;
      end
    end
    r_act = 0; r_as_first = -1; r_as_cnt = 0; r_lds_first = -1; r_lds_cnt = 0;
    r_uds_cnt = 0; r_oe_first = -1; r_oe_cnt = 0; r_rwlo_cnt = 0; r_dtk_first = -1;
    r_be_first = -1; r_vma_first = -1; r_vma_cnt = 0; r_ebad = 0;
    ioreq = 1'b1; iorw = rw; iol = lb; iou = ub;
    if (dt_at == PRE) ndtack = 1'b0;
    if (be_at == PRE) nberr  = 1'b0;
    if (vp_at == PRE) nvpa   = 1'b0;
    seen = 0; done = 0;
    for (int j = 0; j < 400 && !done; j++) begin
      @(negedge clk);
      if (ioact) begin
        seen = 1; ioreq = 1'b0; r_act++;
      end else if (seen) begin
        done = 1;
      end
      if (!done) begin
        if (!nas) begin if (r_as_first < 0) r_as_first = j; r_as_cnt++; end
        if (!nlds) begin if (r_lds_first < 0) r_lds_first = j; r_lds_cnt++; end
        if (!nuds) r_uds_cnt++;
        if (!ndoutoe) begin if (r_oe_first < 0) r_oe_first = j; r_oe_cnt++; end
        if (!iorw_o) r_rwlo_cnt++;
        if (!niodtack && r_dtk_first < 0) r_dtk_first = j;
        if (!nioberr && r_be_first < 0) r_be_first = j;
        if (!nvma) begin if (r_vma_first < 0) r_vma_first = j; r_vma_cnt++; end
        if (e !== (mdl_ecnt >= 12)) r_ebad++;
      end
      if (j == dt_at) ndtack = 1'b0;
      if (j == be_at) nberr  = 1'b0;
      if (j == vp_at) nvpa   = 1'b0;
    end
    r_done = int'(done);
    ndtack = 1'b1; nberr = 1'b1; nvpa = 1'b1; ioreq = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", out_vec(), int'(11'b01111111010));
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Word read, DTACK tied low: zero wait states.
    run_xfer(1'b1, 1'b1, 1'b1, PRE, NEVER, NEVER, -1);
    chk("rd_done", r_done, 1);
    chk("rd_ioact_len", r_act, 8);
    chk("rd_as_first", r_as_first, 2);
    chk("rd_as_len", r_as_cnt, 5);
    chk("rd_lds_len", r_lds_cnt, 5);
    chk("rd_uds_len", r_uds_cnt, 5);
    chk("rd_dtack_at", r_dtk_first, 7);
    chk("rd_berr_never", r_be_first, -1);
    chk("rd_oe_len", r_oe_cnt, 0);
    chk("rd_rw_low", r_rwlo_cnt, 0);
    chk("rd_status_hold", int'(niodtack), 0);

    // Byte write, DTACK 3 CLK after nAS: three S4 wait states.
    run_xfer(1'b0, 1'b1, 1'b0, 5, NEVER, NEVER, -1);
    chk("wr_ioact_len", r_act, 11);
    chk("wr_lds_first", r_lds_first, 4);
    chk("wr_lds_len", r_lds_cnt, 6);
    chk("wr_uds_len", r_uds_cnt, 0);
    chk("wr_oe_first", r_oe_first, 2);
    chk("wr_oe_len", r_oe_cnt, 8);
    chk("wr_as_len", r_as_cnt, 8);
    chk("wr_rw_low", r_rwlo_cnt, 11);
    chk("wr_dtack_at", r_dtk_first, 10);

    // BERR and DTACK together in S4: BERR wins.
    run_xfer(1'b1, 1'b1, 1'b1, 4, 4, NEVER, -1);
    chk("be_ioact_len", r_act, 10);
    chk("be_berr_at", r_be_first, 9);
    chk("be_dtack_never", r_dtk_first, -1);
    chk("be_lds_len", r_lds_cnt, 7);
    chk("be_status_hold", int'({niodtack, nioberr}), 2);

    // VPA with ECnt=10 during S4: VMA at next ECnt 8, S5 after ECnt 19.
    run_xfer(1'b1, 1'b1, 1'b1, NEVER, NEVER, PRE, 5);
    chk("vpa_ioact_len", r_act, 37);
    chk("vpa_vma_first", r_vma_first, 22);
    chk("vpa_vma_len", r_vma_cnt, 14);
    chk("vpa_dtack_at", r_dtk_first, 36);
    chk("vpa_e_bad", r_ebad, 0);

    // No termination: watchdog expires after 255 S4 cycles.
    run_xfer(1'b1, 1'b1, 1'b1, NEVER, NEVER, NEVER, -1);
    chk("to_done", r_done, 1);
    chk("to_ioact_len", r_act, 262);
    chk("to_berr_at", r_be_first, 261);
    chk("to_dtack_never", r_dtk_first, -1);
    chk("to_as_len", r_as_cnt, 259);
    chk("to_e_bad", r_ebad, 0);

    // Reset pulse while waiting in S4.
    @(negedge clk);
    ioreq = 1'b1; iorw = 1'b1; iol = 1'b1; iou = 1'b1;
    @(negedge clk);
    chk("rstmid_accepted", int'(ioact), 1);
    ioreq = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstmid_as_before", int'(nas), 0);
    #2 rst = 1'b1;
    #1 chk("rstmid_outputs", out_vec(), int'(11'b01111111010));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_idle", int'(ioact), 0);

    run_xfer(1'b1, 1'b1, 1'b1, PRE, NEVER, NEVER, -1);
    chk("post_rst_ioact_len", r_act, 8);
    chk("post_rst_dtack_at", r_dtk_first, 7);
    chk("post_rst_berr_never", r_be_first, -1);
    chk("post_rst_e_bad", r_ebad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_master.md
# iob_master

I/O bus master controller: runs MC68000-style asynchronous bus cycles on the slow I/O bus on behalf of the I/O bridge slave. It accepts one transfer per IOREQ handshake, drives AS/LDS/UDS/R/W/VMA and the 6800 E clock, and terminates on DTACK, BERR, VPA or a watchdog timeout. It returns completion status to the slave through IOACT, nIODTACK and nIOBERR. One CLK period equals one 68000 bus state (half a bus clock).

## Interface
- TO_MAX, 255, watchdog limit in CLK cycles spent in S4/VW without termination
- CLK  in  1  I/O bus state clock; all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- IOREQ  in  1  transfer request from the slave, held until IOACT is seen
- IORW  in  1  1 = read, 0 = write; sampled with IOREQ in IDLE
- IOL, IOU  in  1 each  lower/upper byte enable, active-high; sampled with IOREQ
- nDTACK, nBERR, nVPA  in  1 each  asynchronous bus terminations, active-low
- IOACT  out  1  transfer in progress
- nIODTACK  out  1  low = last cycle ended normally (DTACK/VPA)
- nIOBERR  out  1  low = last cycle ended with BERR or timeout
- nAS, nLDS, nUDS  out  1 each  bus strobes
- IORW_o  out  1  bus R/W
- nVMA  out  1  valid memory address, E-synchronous cycles
- E  out  1  6800 E clock
- nDoutOE  out  1  write data output enable
- nDinLE  out  1  read data latch; transparent while low

## Operation
- Reset values: IOACT=0, nIODTACK=1, nIOBERR=1, nAS=nLDS=nUDS=1, IORW_o=1, nVMA=1, E=0, nDoutOE=1, nDinLE=0. E counter=0, state=IDLE, watchdog=0.
- Synchronizers: nDTACK, nBERR and nVPA each pass through 2 flops. Terminations are decided only on the synchronized values (DTs, BEs, VPs).
- E counter ECnt: 0..19, wraps to 0, free-running from reset. E=1 while ECnt is 12..19 (12 low, 8 high).
- States: IDLE, S0, S1, S2, S3, S4, VW, S5, S6, S7. All outputs are registered and decoded from the next state.
- IDLE:
  - If IOREQ=1, go to S0.
  - Latch IORW/IOL/IOU.
  - Set IOACT=1, nIODTACK=1, nIOBERR=1.
- S0: IORW_o = latched RW. Go to S1.
- S1: go to S2.
- S2:
  - nAS=0.
  - Read: assert nLDS/nUDS per latched IOL/IOU.
  - Write: nDoutOE=0.
  - Go to S3.
- S3: go to S4.
- S4:
  - Write: assert strobes here.
  - Priority: BEs > DTs > VPs.
  - BEs: set berr flag, go to S5. DTs: go to S5. VPs: go to VW.
  - Otherwise stay and count the watchdog.
- VW:
  - nVMA=0 on the first cycle where ECnt==8 (ECnt reached after VW entry).
  - With nVMA low, when ECnt==19, go to S5.
  - A BEs in VW still takes priority.
- S5: go to S6.
- S6: nDinLE=1 on entry, which closes the read latch. Go to S7.
- S7, on entry:
  - nAS, nLDS, nUDS, nVMA go to 1; nDoutOE=1.
  - nIODTACK=0, or nIOBERR=0 if the berr flag is set.
  - Go to IDLE.
- Return to IDLE: IOACT=0, IORW_o=1, nDinLE=0. Status outputs hold until the next IDLE→S0.
- Watchdog: counts cycles in S4/VW and clears on S0. At TO_MAX it acts as BEs.
- IOREQ is ignored outside IDLE. After S7 there is at least 1 IDLE cycle with IOACT=0 before the next accept.
- Reset asserted mid-cycle returns all outputs to reset values immediately. No status is reported for the aborted cycle.

## Timing
- IOREQ high at edge k in IDLE → IOACT=1 after edge k.
- nAS falls after edge k+2.
- With DTs already true in S4, the cycle lasts 8 CLK: IOACT is high for edges k..k+7 and falls after k+8. nIODTACK falls after k+7.
- A raw nDTACK must be low ≥2 edges before the S4 sample to avoid a wait state. Each extra S4 cycle adds 1 CLK.
- Read strobes span S2..S6. Write strobes span S4..S6.
- nIODTACK/nIOBERR are valid from S7 onward, always before IOACT falls.

## Test plan
- Word read, nDTACK tied low → strobes both low for 5 CLK; nIODTACK=0 at S7; IOACT high exactly 8 CLK; nIOBERR stays 1.
- Byte write (IOL=1, IOU=0), nDTACK low 3 CLK after nAS → nUDS stays 1; nLDS low from S4; nDoutOE low S2..S6; cycle length 8 + wait count.
- nBERR and nDTACK low together in S4 → nIOBERR=0, nIODTACK=1, IOACT falls normally.
- nVPA low, ECnt=10 at S4 → nVMA falls at the next ECnt==8; S5 is entered after ECnt==19; nIODTACK=0.
- No termination → S4 holds for TO_MAX=255 cycles, then nIOBERR=0 and IOACT drops.
- RST pulse in S4 → nAS=1, IOACT=0, E=0 immediately. Next IOREQ runs a clean 8-CLK cycle.
